// File: rtl/subleq_pkg.sv
// subleq_pkg
// Shared constants for the SUBLEQ core and its host-side I/O bridge.
//   SUBLEQ_D         : core data width
//   SUBLEQ_IO_DEPTH  : default bridge output FIFO depth
//   SUBLEQ_IO_HOLD   : default minimum hold time of a host byte on core_inp
//   subleq_cnt_width : bit width able to hold the values 0..n-1 (at least 1)
package subleq_pkg;

  localparam int SUBLEQ_D        = 8;
  localparam int SUBLEQ_IO_DEPTH = 4;
  localparam int SUBLEQ_IO_HOLD  = 4;

  function automatic int subleq_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/subleq_io_bridge_if.sv
// subleq_io_bridge_if
// Host-facing valid/ready streams of the SUBLEQ I/O bridge.
//   out_data/out_valid/out_ready : core output values, bridge -> host
//   in_data/in_valid/in_ready    : host bytes, host -> bridge -> core
// Modports:
//   slave  : the bridge side
//   master : the host side
interface subleq_io_bridge_if
  import subleq_pkg::*;
#(
  parameter int D = SUBLEQ_D
);

  logic [D-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [D-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport slave (
    output out_data, out_valid, in_ready,
    input  out_ready, in_data, in_valid
  );

  modport master (
    input  out_data, out_valid, in_ready,
    output out_ready, in_data, in_valid
  );

endinterface

// File: rtl/subleq_io_fifo.sv
// subleq_io_fifo
// First-word-fall-through FIFO holding captured core output values.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless popping the same cycle)
//   push_data  : value to store
//   pop        : remove the head entry (ignored when empty)
//   full/empty : occupancy status
//   head       : oldest entry, 0 while empty
module subleq_io_fifo
  import subleq_pkg::*;
#(
  parameter int D     = SUBLEQ_D,
  parameter int DEPTH = SUBLEQ_IO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [D-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [D-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [D-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // The extra pointer MSB tells a full buffer (MSBs differ) from an empty one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full buffer still fits when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/subleq_io_bridge.sv
// subleq_io_bridge
// Host-side adapter for the SUBLEQ core's 8-bit inp/oup pair.
// Every change on core_oup is captured into a small FIFO and offered to the
// host as a valid/ready stream; host bytes accepted from the input stream are
// driven onto core_inp and held for at least HOLD cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   core_oup   : core output bus (watched for changes)
//   core_inp   : core input bus, registered
//   host       : host streams (subleq_io_bridge_if.slave)
//   ovf        : sticky overflow flag, set when a captured value is dropped
//   ovf_clr    : clears ovf (set wins over clear)
// Configuration:
//   SUBLEQ_IO_OVF_EN defined   -> ovf register implemented
//   SUBLEQ_IO_OVF_EN undefined -> ovf tied to 0, ovf_clr ignored
module subleq_io_bridge
  import subleq_pkg::*;
#(
  parameter int D     = SUBLEQ_D,
  parameter int DEPTH = SUBLEQ_IO_DEPTH,
  parameter int HOLD  = SUBLEQ_IO_HOLD
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D-1:0]         core_oup,
  output logic [D-1:0]         core_inp,
  subleq_io_bridge_if.slave    host,
  output logic                 ovf,
  input  logic                 ovf_clr
);

  localparam int HW = subleq_cnt_width(HOLD);

  logic [D-1:0]  prev_oup;
  logic          change;
  logic          pop;
  logic          full;
  logic          empty;
  logic          drop;
  logic [HW-1:0] hold_cnt;
  logic          accept;

  assign change = (core_oup != prev_oup);
  assign pop    = host.out_ready & ~empty;
  assign drop   = change & full & ~pop;

  subleq_io_fifo #(
    .D     (D),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (change),
    .push_data (core_oup),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (host.out_data)
  );

  assign host.out_valid = ~empty;

  // prev_oup follows the bus even when the push is dropped, so a value that
  // did not fit is not pushed again on the following cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_oup <= '0;
    end else if (change) begin
      prev_oup <= core_oup;
    end
  end

  assign host.in_ready = (hold_cnt == '0);
  assign accept        = host.in_valid & host.in_ready;

  // An accepted byte blocks the next one for HOLD-1 further cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_inp <= '0;
      hold_cnt <= '0;
    end else if (accept) begin
      core_inp <= host.in_data;
      hold_cnt <= HW'(HOLD - 1);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

`ifdef SUBLEQ_IO_OVF_EN
  // A drop in the same cycle as ovf_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic ovf_unused;

  assign ovf        = 1'b0;
  assign ovf_unused = ovf_clr | drop;
`endif

endmodule

// File: doc/subleq_io_bridge.md
# subleq_io_bridge

Host-side I/O adapter for the SUBLEQ core's 8-bit `inp`/`oup` pair. It watches the core's output bus, captures every value change into a small FIFO, and presents those values to the host as a valid/ready stream. In the other direction it accepts host bytes on a valid/ready stream and drives them onto the core's input bus. Each accepted byte is held stable for a programmable minimum number of cycles so the core can sample it. The bridge sits between `SUBLEQ`/`CORE` and the testbench or host logic.

## Interface
Parameters:
- `D`, 8: data width; matches the core's `D`.
- `DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `HOLD`, 4: minimum cycles a host byte stays on `core_inp` before the next byte is accepted; ≥1.

Ports:
- One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `core_oup` in D: core output bus.
- `core_inp` out D: core input bus, registered.
- `out_data` out D: head of output FIFO.
- `out_valid` out 1: FIFO non-empty.
- `out_ready` in 1: host consumes head.
- `in_data` in D: host byte for core.
- `in_valid` in 1: host byte present.
- `in_ready` out 1: bridge can accept host byte.
- `ovf` out 1: sticky overflow flag (see Configuration).
- `ovf_clr` in 1: clears `ovf`.

## Operation
- Reset values:
  - `core_inp`=0.
  - Internal `prev_oup`=0.
  - FIFO empty; `out_valid`=0, `out_data`=0.
  - `in_ready`=1; `hold_cnt`=0.
  - `ovf`=0.
- Change detect: at each edge, if `core_oup != prev_oup`, push `core_oup` and set `prev_oup<=core_oup`. A constant bus produces no pushes. A value of 0 immediately after reset is not pushed.
- Output FIFO:
  - First-word-fall-through; `out_data` = oldest entry whenever `out_valid`=1.
  - Pop on `out_valid & out_ready`.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty are decided by comparing the MSB and the remaining bits.
- Boundaries:
  - Push when full without pop: new value dropped, FIFO contents unchanged, overflow event raised.
  - Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
  - `out_ready` while empty: ignored.
  - `prev_oup` updates even on a dropped push, so the same value is not retried.
- Input path:
  - `in_ready = (hold_cnt==0)`.
  - On `in_valid & in_ready`: `core_inp<=in_data` and `hold_cnt<=HOLD-1`.
  - Otherwise `hold_cnt` decrements while non-zero.
  - With HOLD=1, `in_ready` stays high and one byte can be accepted per cycle.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded.

## Timing
- `core_oup` change sampled at edge N → `out_valid`=1 and `out_data` valid after edge N (1-cycle latency).
- Pop at edge N → next entry (or `out_valid`=0) visible after edge N.
- Byte accepted at edge N → on `core_inp` after edge N.
- After acceptance, `in_ready` is low for HOLD-1 cycles and high again after edge N+HOLD-1.
- Overflow event at edge N → `ovf`=1 after edge N.
- `ovf_clr` and an overflow event in the same cycle: set wins.

## Configuration
- `SUBLEQ_IO_OVF_EN` defined: sticky `ovf` register implemented; set by a dropped push, cleared by `ovf_clr`.
- Undefined: `ovf` tied to 0 and `ovf_clr` ignored. Drop-on-full behaviour is unchanged.

## Structure
- Shared package `subleq_pkg`:
  - data-width constant `SUBLEQ_D`=8;
  - default `SUBLEQ_IO_DEPTH`=4;
  - default `SUBLEQ_IO_HOLD`=4.
- One sub-module `subleq_io_fifo` (parameters D, DEPTH; push/pop/full/empty/head). Change detection, the hold counter and the overflow flag stay in `subleq_io_bridge`.

## Test plan
- Reset with `core_oup`=0x00, then hold → `out_valid`=0 for 20 cycles; `core_inp`=0x00, `in_ready`=1.
- `core_oup` 0x00→0x05→0x05→0x0A with `out_ready`=1 → exactly two beats, 0x05 then 0x0A, each 1 cycle after its change.
- `out_ready`=0, `core_oup` changes to 0x01..0x05 on consecutive cycles (DEPTH=4):
  - 0x01–0x04 stored; 0x05 dropped; `ovf`=1 with macro, 0 without.
  - Then `out_ready`=1 → 0x01,0x02,0x03,0x04.
- FIFO full plus a new change with `out_ready`=1 in the same cycle → no overflow; head advances, count stays 4, new value at tail.
- HOLD=4, `in_valid`=1 with 0x11 then 0x22:
  - 0x11 on `core_inp` after edge N; `in_ready` low for 3 cycles.
  - 0x22 accepted at edge N+4.
- Assert `rst_n`=0 with 3 entries queued and `hold_cnt`≠0 → `out_valid`=0, `in_ready`=1, `core_inp`=0, `ovf`=0 without waiting for a clock edge.
